// File: rtl/hazard_scheduler_pkg.sv
// Shared definitions for the pipeline hazard scheduler: opcodes, functs,
// instruction classes, forward-select codes and the scoreboard entry type.
package hazard_scheduler_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    typedef enum logic [3:0] {
        CLS_NOP, CLS_CAL_R, CLS_CAL_I, CLS_LOAD, CLS_STORE, CLS_BEQ,
        CLS_JAL, CLS_JR, CLS_MD, CLS_MF, CLS_MT
    } instr_class_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    // Source not read: larger than any Tnew, so it can never cause a stall.
    localparam logic [1:0] TUSE_NONE = 2'd3;

    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       is_md;
        logic       is_div;
    } sb_entry_t;

    function automatic logic [1:0] sat_dec(input logic [1:0] v);
        return (v == 2'd0) ? 2'd0 : v - 2'd1;
    endfunction

endpackage

// File: rtl/hazard_decode.sv
// Combinational decoder: classifies the D-stage instruction and extracts the
// source/destination registers with their Tuse/Tnew timing.
module hazard_decode
    import hazard_scheduler_pkg::*;
(
    input  logic [31:0]  i_instr,
    output instr_class_t o_class,
    output logic [4:0]   o_rs,
    output logic [4:0]   o_rt,
    output logic [4:0]   o_dst,
    output logic [1:0]   o_tuse_rs,
    output logic [1:0]   o_tuse_rt,
    output logic [1:0]   o_tnew,
    output logic         o_is_div
);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rs_f;
    logic [4:0] w_rt_f;
    logic [4:0] w_rd_f;
    logic       w_unused_shamt;

    assign w_op           = i_instr[31:26];
    assign w_funct        = i_instr[5:0];
    assign w_rs_f         = i_instr[25:21];
    assign w_rt_f         = i_instr[20:16];
    assign w_rd_f         = i_instr[15:11];
    assign w_unused_shamt = ^i_instr[10:6];

    // Class lookup; unread sources are zeroed so they never match a destination.
    always_comb begin
        o_class   = CLS_NOP;
        o_rs      = 5'd0;
        o_rt      = 5'd0;
        o_dst     = 5'd0;
        o_tuse_rs = TUSE_NONE;
        o_tuse_rt = TUSE_NONE;
        o_tnew    = 2'd0;
        o_is_div  = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                case (w_funct)
                    FN_ADDU, FN_SUBU: begin
                        o_class = CLS_CAL_R;
                        o_rs = w_rs_f; o_tuse_rs = 2'd1;
                        o_rt = w_rt_f; o_tuse_rt = 2'd1;
                        o_dst = w_rd_f; o_tnew = 2'd1;
                    end
                    FN_JR: begin
                        o_class = CLS_JR;
                        o_rs = w_rs_f; o_tuse_rs = 2'd0;
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        o_class = CLS_MD;
                        o_rs = w_rs_f; o_tuse_rs = 2'd1;
                        o_rt = w_rt_f; o_tuse_rt = 2'd1;
                        o_is_div = (w_funct == FN_DIV) || (w_funct == FN_DIVU);
                    end
                    FN_MFHI, FN_MFLO: begin
                        o_class = CLS_MF;
                        o_dst = w_rd_f; o_tnew = 2'd1;
                    end
                    FN_MTHI, FN_MTLO: begin
                        o_class = CLS_MT;
                        o_rs = w_rs_f; o_tuse_rs = 2'd1;
                    end
                    default: o_class = CLS_NOP;
                endcase
            end
            OP_ORI, OP_LUI, OP_ADDIU: begin
                o_class = CLS_CAL_I;
                o_rs = w_rs_f; o_tuse_rs = 2'd1;
                o_dst = w_rt_f; o_tnew = 2'd1;
            end
            OP_LW: begin
                o_class = CLS_LOAD;
                o_rs = w_rs_f; o_tuse_rs = 2'd1;
                o_dst = w_rt_f; o_tnew = 2'd2;
            end
            OP_SW: begin
                o_class = CLS_STORE;
                o_rs = w_rs_f; o_tuse_rs = 2'd1;
                o_rt = w_rt_f; o_tuse_rt = 2'd2;
            end
            OP_BEQ: begin
                o_class = CLS_BEQ;
                o_rs = w_rs_f; o_tuse_rs = 2'd0;
                o_rt = w_rt_f; o_tuse_rt = 2'd0;
            end
            OP_JAL: begin
                o_class = CLS_JAL;
                o_dst = 5'd31; o_tnew = 2'd0;
            end
            default: o_class = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/hazard_scheduler.sv
// Hazard and forwarding controller for a 5-stage MIPS pipeline. Shadows the
// E/M/W destinations with Tnew countdowns and derives stall, bubble, forward
// selects and the mult/div busy interlock from them.
module hazard_scheduler
    import hazard_scheduler_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_D,
    output logic        stall_F,
    output logic        stall_D,
    output logic        flush_E,
    output logic [1:0]  ForwardRSD,
    output logic [1:0]  ForwardRTD,
    output logic [1:0]  ForwardRSE,
    output logic [1:0]  ForwardRTE,
    output logic        ForwardRTM,
    output logic        md_busy
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    instr_class_t w_class;
    logic [4:0]   w_rs, w_rt, w_dst;
    logic [1:0]   w_tuse_rs, w_tuse_rt, w_tnew;
    logic         w_is_div;
    sb_entry_t    w_dec_entry;
    sb_entry_t    w_e_aged;
    sb_entry_t    r_sb_e, r_sb_m, r_sb_w;
    logic [3:0]   r_busy_cnt;
    logic         w_md_class, w_stall;
    logic         w_unused_sb;

    hazard_decode u_decode (
        .i_instr   (instr_D),
        .o_class   (w_class),
        .o_rs      (w_rs),
        .o_rt      (w_rt),
        .o_dst     (w_dst),
        .o_tuse_rs (w_tuse_rs),
        .o_tuse_rt (w_tuse_rt),
        .o_tnew    (w_tnew),
        .o_is_div  (w_is_div)
    );

    assign w_md_class  = (w_class == CLS_MD) || (w_class == CLS_MF) || (w_class == CLS_MT);
    assign w_dec_entry = '{dst: w_dst, tnew: w_tnew, rs: w_rs, rt: w_rt,
                           is_md: (w_class == CLS_MD), is_div: w_is_div};
    assign w_unused_sb = ^{r_sb_w.tnew, r_sb_w.rs, r_sb_w.rt, r_sb_w.is_md, r_sb_w.is_div,
                           r_sb_m.rs, r_sb_m.is_md, r_sb_m.is_div};

    // A producer in E or M is still too young if its result appears later than the consumer needs it.
    function automatic logic src_hazard(input logic [4:0] r, input logic [1:0] tuse,
                                        input sb_entry_t e, input sb_entry_t m);
        return (r != 5'd0) &&
               (((e.dst == r) && (e.tnew > tuse)) || ((m.dst == r) && (m.tnew > tuse)));
    endfunction

    // M wins when its value is ready now; otherwise fall back to W, then the regfile.
    function automatic logic [1:0] fwd_sel(input logic [4:0] r, input sb_entry_t m,
                                           input sb_entry_t w);
        if ((r != 5'd0) && (m.dst == r) && (m.tnew == 2'd0)) return FWD_M;
        if ((r != 5'd0) && (w.dst == r))                      return FWD_W;
        return FWD_RF;
    endfunction

    // Stall decision for the instruction in D, including the mult/div interlock.
    always_comb begin
        w_stall = src_hazard(w_rs, w_tuse_rs, r_sb_e, r_sb_m) ||
                  src_hazard(w_rt, w_tuse_rt, r_sb_e, r_sb_m) ||
                  (w_md_class && (r_sb_e.is_md || (r_busy_cnt != 4'd0)));
        w_e_aged      = r_sb_e;
        w_e_aged.tnew = sat_dec(r_sb_e.tnew);
    end

    // Outputs are held at zero for as long as reset is asserted.
    always_comb begin
        stall_F    = 1'b0;
        stall_D    = 1'b0;
        flush_E    = 1'b0;
        ForwardRSD = FWD_RF;
        ForwardRTD = FWD_RF;
        ForwardRSE = FWD_RF;
        ForwardRTE = FWD_RF;
        ForwardRTM = 1'b0;
        md_busy    = 1'b0;
        if (reset) begin
            stall_F    = w_stall;
            stall_D    = w_stall;
            flush_E    = w_stall;
            ForwardRSD = fwd_sel(w_rs, r_sb_m, r_sb_w);
            ForwardRTD = fwd_sel(w_rt, r_sb_m, r_sb_w);
            ForwardRSE = fwd_sel(r_sb_e.rs, r_sb_m, r_sb_w);
            ForwardRTE = fwd_sel(r_sb_e.rt, r_sb_m, r_sb_w);
            ForwardRTM = (r_sb_m.rt != 5'd0) && (r_sb_w.dst == r_sb_m.rt);
            md_busy    = (r_busy_cnt != 4'd0);
        end
    end

    // Scoreboard advances with the pipeline; busy counter reloads when a mult/div leaves E.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sb_e     <= '0;
            r_sb_m     <= '0;
            r_sb_w     <= '0;
            r_busy_cnt <= 4'd0;
        end else begin
            r_sb_w <= r_sb_m;
            r_sb_m <= w_e_aged;
            r_sb_e <= w_stall ? '0 : w_dec_entry;
            if (r_sb_e.is_md)
                r_busy_cnt <= r_sb_e.is_div ? DIV_LOAD : MULT_LOAD;
            else if (r_busy_cnt != 4'd0)
                r_busy_cnt <= r_busy_cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: walks hand-built instruction sequences
// through D and checks stall/forward/busy outputs against hand-derived values.
module tb_hazard_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_D;
    logic        stall_F, stall_D, flush_E, ForwardRTM, md_busy;
    logic [1:0]  ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    hazard_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_D    (instr_D),
        .stall_F    (stall_F),
        .stall_D    (stall_D),
        .flush_E    (flush_E),
        .ForwardRSD (ForwardRSD),
        .ForwardRTD (ForwardRTD),
        .ForwardRSE (ForwardRSE),
        .ForwardRTE (ForwardRTE),
        .ForwardRTM (ForwardRTM),
        .md_busy    (md_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt);
        return {op, rs, rt, 16'd0};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one instruction in D for one cycle; outputs settle 1 time unit after the falling edge.
    task automatic drive(input logic [31:0] ins);
        @(negedge clk);
        instr_D = ins;
        cyc++;
        #1;
        $display("cycle %0d instr=%08h stall=%0b fwdD=%0d/%0d fwdE=%0d/%0d rtm=%0b busy=%0b",
                 cyc, ins, stall_D, ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE,
                 ForwardRTM, md_busy);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) drive(32'd0);
    endtask

    initial begin
        reset   = 1'b0;
        instr_D = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", {7'd0, stall_F}, 8'd0);
        chk("reset_busy", {7'd0, md_busy}, 8'd0);
        chk("reset_fwdD", {4'd0, ForwardRSD, ForwardRTD}, 8'd0);
        @(negedge clk);
        reset = 1'b1;

        // lw $1 then addu $2,$1,$1: one bubble, then the load value comes from W
        drive(i_ins(6'h23, 5'd0, 5'd1));
        chk("t1_no_stall_lw", {7'd0, stall_D}, 8'd0);
        drive(r_ins(5'd1, 5'd1, 5'd2, 6'h21));
        chk("t1_stall_F", {7'd0, stall_F}, 8'd1);
        chk("t1_stall_D", {7'd0, stall_D}, 8'd1);
        chk("t1_flush_E", {7'd0, flush_E}, 8'd1);
        drive(r_ins(5'd1, 5'd1, 5'd2, 6'h21));
        chk("t1_release", {7'd0, stall_D}, 8'd0);
        drive(32'd0);
        chk("t1_fwd_rse", {6'd0, ForwardRSE}, 8'd2);
        chk("t1_fwd_rte", {6'd0, ForwardRTE}, 8'd2);
        drain();

        // addu $10 back-to-back: E-stage operands forwarded from M
        drive(r_ins(5'd4, 5'd5, 5'd10, 6'h21));
        drive(r_ins(5'd10, 5'd10, 5'd10, 6'h21));
        chk("tm_no_stall", {7'd0, stall_D}, 8'd0);
        chk("tm_fwd_rsd", {6'd0, ForwardRSD}, 8'd0);
        drive(32'd0);
        chk("tm_fwd_rse", {6'd0, ForwardRSE}, 8'd1);
        chk("tm_fwd_rte", {6'd0, ForwardRTE}, 8'd1);
        drain();

        // addu $3 then beq $3,$0: one stall, then D forward from M
        drive(r_ins(5'd4, 5'd5, 5'd3, 6'h21));
        drive(i_ins(6'h04, 5'd3, 5'd0));
        chk("t2_stall", {7'd0, stall_D}, 8'd1);
        drive(i_ins(6'h04, 5'd3, 5'd0));
        chk("t2_release", {7'd0, stall_D}, 8'd0);
        chk("t2_fwd_rsd", {6'd0, ForwardRSD}, 8'd1);
        chk("t2_fwd_rtd", {6'd0, ForwardRTD}, 8'd0);
        drive(32'd0);
        chk("t2_after", {7'd0, stall_D}, 8'd0);
        drain();

        // lw $6 then beq $6,$6: two stalls, then D forward from W
        drive(i_ins(6'h23, 5'd0, 5'd6));
        drive(i_ins(6'h04, 5'd6, 5'd6));
        chk("t3_stall1", {7'd0, stall_D}, 8'd1);
        drive(i_ins(6'h04, 5'd6, 5'd6));
        chk("t3_stall2", {7'd0, stall_D}, 8'd1);
        drive(i_ins(6'h04, 5'd6, 5'd6));
        chk("t3_release", {7'd0, stall_D}, 8'd0);
        chk("t3_fwd_rsd", {6'd0, ForwardRSD}, 8'd2);
        chk("t3_fwd_rtd", {6'd0, ForwardRTD}, 8'd2);
        drain();

        // lw $9 then sw $9: no stall, store data forwarded from W in M
        drive(i_ins(6'h23, 5'd0, 5'd9));
        drive(i_ins(6'h2b, 5'd0, 5'd9));
        chk("ts_no_stall", {7'd0, stall_D}, 8'd0);
        drive(32'd0);
        chk("ts_rtm_early", {7'd0, ForwardRTM}, 8'd0);
        chk("ts_rte", {6'd0, ForwardRTE}, 8'd0);
        drive(32'd0);
        chk("ts_rtm", {7'd0, ForwardRTM}, 8'd1);
        drain();

        // mult then mflo: 6 stall cycles, busy high for the middle 5
        drive(r_ins(5'd1, 5'd2, 5'd0, 6'h18));
        for (int k = 0; k < 7; k++) begin
            drive(r_ins(5'd0, 5'd0, 5'd7, 6'h12));
            chk($sformatf("t4_stall_k%0d", k), {7'd0, stall_D}, {7'd0, k < 6});
            chk($sformatf("t4_busy_k%0d", k), {7'd0, md_busy}, {7'd0, (k >= 1) && (k <= 5)});
        end
        drain();

        // div, then reset mid-count: everything cleared, mfhi proceeds
        drive(r_ins(5'd1, 5'd2, 5'd0, 6'h1a));
        chk("t5_div_nostall", {7'd0, stall_D}, 8'd0);
        drive(32'd0);
        chk("t5_busy_pre", {7'd0, md_busy}, 8'd0);
        drive(32'd0);
        chk("t5_busy", {7'd0, md_busy}, 8'd1);
        drive(r_ins(5'd0, 5'd0, 5'd9, 6'h10));
        chk("t5_mfhi_stall", {7'd0, stall_D}, 8'd1);
        reset = 1'b0;
        #1;
        chk("t5_rst_stall", {7'd0, stall_F}, 8'd0);
        chk("t5_rst_flush", {7'd0, flush_E}, 8'd0);
        chk("t5_rst_busy", {7'd0, md_busy}, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(r_ins(5'd0, 5'd0, 5'd9, 6'h10));
        chk("t5_post_stall", {7'd0, stall_D}, 8'd0);
        chk("t5_post_busy", {7'd0, md_busy}, 8'd0);
        drain();

        // lw $0 then addu $8,$0,$0: $0 never stalls or forwards
        drive(i_ins(6'h23, 5'd0, 5'd0));
        drive(r_ins(5'd0, 5'd0, 5'd8, 6'h21));
        chk("t6_no_stall", {7'd0, stall_D}, 8'd0);
        chk("t6_fwdD", {4'd0, ForwardRSD, ForwardRTD}, 8'd0);
        drive(32'd0);
        chk("t6_fwdE", {4'd0, ForwardRSE, ForwardRTE}, 8'd0);
        chk("t6_stall2", {7'd0, stall_D}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
